serial_frame_sequencer: RTL
===========================

Name: serial_frame_sequencer

Overview:
Sequences the vending-machine serial display/shift-register datapath. On a start request it captures two 4-bit operands and emits a fixed-length serial frame: operand A, a zero gap, operand B, then zero padding. It drives a per-bit shift strobe and a single storage-latch pulse, and reports progress through a busy/done handshake. It sits between the vending FSM, which supplies the item/price nibbles, and the external shift-register chain.

Parameters:
GAP_BITS, 4, number of zero bits between A and B
PAD_BITS, 8, number of zero bits after B
BIT_CYCLES, 1, clock cycles each bit is held; legal range is 1 and above

Ports:
clk  input  1  system clock; all state changes on the rising edge
clr  input  1  reset, asynchronous, active-high
start  input  1  frame request; sampled only in IDLE
abort  input  1  synchronous frame cancel; honoured in SHIFT only
a  input  4  operand A; shifted first, LSB first
b  input  4  operand B; LSB first
ser_data  output  1  serial data to the shift-register chain
ser_shift  output  1  one-cycle shift strobe per bit
ser_latch  output  1  one-cycle storage-latch pulse after the last bit
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- FRAME_LEN = 8 + GAP_BITS + PAD_BITS (20 at defaults). The bit index counter is $clog2(FRAME_LEN+1) bits wide. The hold counter is max(1,$clog2(BIT_CYCLES)) bits wide.
- Frame bit k, using the captured operands a_q and b_q:
  - k<4: a_q[k]
  - 4≤k<4+GAP_BITS: 0
  - next 4 bits: b_q[k-4-GAP_BITS]
  - remaining bits: 0
- All outputs are registered.
- Reset (clr=1, asynchronous): state=IDLE; ser_data, ser_shift, ser_latch, busy and done are 0; all counters are 0; a_q and b_q are 0.
- States: IDLE, SHIFT, LATCH, DONE.
  - IDLE: if start=1 at an edge, capture a→a_q and b→b_q, go to SHIFT, and present bit 0 at that same edge. Otherwise stay in IDLE.
  - SHIFT: ser_data holds bit k for BIT_CYCLES cycles. ser_shift=1 only in the last cycle of each bit period. After bit FRAME_LEN-1 has been strobed, go to LATCH.
  - LATCH: one cycle with ser_latch=1, ser_data=0, ser_shift=0. Go to DONE.
  - DONE: one cycle with done=1. Go to IDLE.
- Latency at BIT_CYCLES=1, with start accepted at edge N:
  - ser_shift high in cycles N..N+19
  - ser_latch in cycle N+20
  - done in cycle N+21
  - IDLE, busy=0, at N+22
- General case: busy lasts FRAME_LEN*BIT_CYCLES+2 cycles.
- start outside IDLE is ignored; it is not queued. A start held high continuously begins a new frame at the edge where the state is IDLE again, giving one idle cycle between frames.
- a and b changing during a frame have no effect, because only a_q and b_q are used.
- abort=1 in SHIFT: next state is IDLE. ser_data, ser_shift and busy go to 0. No ser_latch and no done are issued. abort is ignored in the other states. If start and abort arrive together in IDLE, start is accepted.
- clr mid-frame: immediate return to reset values; no latch pulse. The next start produces a complete, correct frame.
- ser_shift and ser_latch are never high in the same cycle.

Test Plan:
- Reset values: assert clr asynchronously between edges → all outputs 0 immediately; after release, busy=0 until start.
- Basic frame: BIT_CYCLES=1, a=4'b1011, b=4'b0110, one-cycle start → ser_data sampled on the 20 ser_shift pulses is 1,1,0,1,0,0,0,0,0,1,1,0 followed by 8 zeros. Then ser_latch at cycle 20, done at cycle 21, busy high for exactly 22 cycles.
- Operand and start isolation: change a to 4'h0 and pulse start at bit 5 of the basic frame → serial stream is unchanged and exactly one frame is produced.
- Slow bits: BIT_CYCLES=3, a=4'hF, b=4'h0 → ser_shift is high every 3rd cycle for 20 pulses. ser_data is 1 for the first 12 cycles, then 0. ser_latch arrives 60 cycles after start acceptance.
- Cancel: abort during bit 7 → busy=0 and ser_data=0 at the next edge, with no ser_latch and no done. Then clr during bit 10 of a new frame → outputs 0 immediately. A following start yields a full, correct 22-cycle frame.
- Back-to-back: start held high for 60 cycles at BIT_CYCLES=1 → frames begin 23 cycles apart, each with exactly one ser_latch and one done.

Source files
------------

// File: rtl/serial_frame_sequencer.sv
// serial_frame_sequencer: emits A, zero gap, B, zero pad as a serial frame with shift strobes, a latch pulse and a busy/done handshake.
module serial_frame_sequencer #(
  parameter int GAP_BITS   = 4,
  parameter int PAD_BITS   = 8,
  parameter int BIT_CYCLES = 1
) (
  input  logic       i_clk,
  input  logic       i_clr,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic       o_ser_data,
  output logic       o_ser_shift,
  output logic       o_ser_latch,
  output logic       o_busy,
  output logic       o_done
);
  localparam int FRAME_LEN = 8 + GAP_BITS + PAD_BITS;
  localparam int IW = $clog2(FRAME_LEN + 1);
  localparam int HW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(FRAME_LEN - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(BIT_CYCLES - 1);
  localparam logic ONE_CYC = (BIT_CYCLES == 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_t;

  state_t r_state, w_state;
  logic [IW-1:0] r_bit, w_bit;
  logic [HW-1:0] r_hold, w_hold;
  logic [3:0] r_a, w_a, r_b, w_b;
  logic r_data, w_data, r_shift, w_shift, r_latch, w_latch, r_busy, r_done, w_done;

  function automatic logic frame_bit(input logic [IW-1:0] k, input logic [3:0] qa, input logic [3:0] qb);
    int kk;
    kk = int'(k);
    return (kk < 4) ? qa[2'(kk)] :
           (kk < 4 + GAP_BITS) ? 1'b0 :
           (kk < 8 + GAP_BITS) ? qb[2'(kk - 4 - GAP_BITS)] : 1'b0;
  endfunction

  always_comb begin
    w_state = r_state;
    w_bit   = r_bit;
    w_hold  = r_hold;
    w_a     = r_a;
    w_b     = r_b;
    w_data  = 1'b0;
    w_shift = 1'b0;
    w_latch = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      IDLE: if (i_start) begin
        w_state = SHIFT;
        w_a     = i_a;
        w_b     = i_b;
        w_bit   = '0;
        w_hold  = '0;
        w_data  = i_a[0];
        w_shift = ONE_CYC;
      end
      SHIFT: if (i_abort) begin
        w_state = IDLE;
        w_bit   = '0;
        w_hold  = '0;
      end else if (r_hold == HOLD_LAST) begin
        w_hold = '0;
        if (r_bit == LAST_BIT) begin
          w_state = LATCH;
          w_bit   = '0;
          w_latch = 1'b1;
        end else begin
          w_bit   = r_bit + IW'(1);
          w_data  = frame_bit(w_bit, r_a, r_b);
          w_shift = ONE_CYC;
        end
      end else begin
        // mid bit period: hold data, strobe only on the period's final cycle
        w_hold  = r_hold + HW'(1);
        w_data  = r_data;
        w_shift = (w_hold == HOLD_LAST);
      end
      LATCH: begin
        w_state = DONE;
        w_done  = 1'b1;
      end
      DONE: w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_state <= IDLE;
      r_bit   <= '0;
      r_hold  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_data  <= 1'b0;
      r_shift <= 1'b0;
      r_latch <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_bit   <= w_bit;
      r_hold  <= w_hold;
      r_a     <= w_a;
      r_b     <= w_b;
      r_data  <= w_data;
      r_shift <= w_shift;
      r_latch <= w_latch;
      r_busy  <= (w_state != IDLE);
      r_done  <= w_done;
    end
  end

  assign o_ser_data  = r_data;
  assign o_ser_shift = r_shift;
  assign o_ser_latch = r_latch;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
endmodule
